// File: rtl/key_sched_dec.sv
// DES decryption key schedule: loads PC-1(k) on req and emits K16..K1, one per RUN cycle.
// Optional key_err parity flag is built when KEY_SCHED_DEC_PARITY_CHK_EN is defined.
module key_sched_dec (
   input  logic        clk,
   input  logic        rst,
   input  logic        req,
   input  logic [63:0] k,
   output logic        busy,
   output logic [47:0] rk,
   output logic        rk_valid,
   output logic [3:0]  rnd,
   output logic        done
`ifdef KEY_SCHED_DEC_PARITY_CHK_EN
   ,
   output logic        key_err
`endif
);

   typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

   // Tables hold FIPS 46 bit numbers (1 = MSB of the source vector).
   localparam int PC1_TAB [56] = '{
      57, 49, 41, 33, 25, 17,  9,  1, 58, 50, 42, 34, 26, 18,
      10,  2, 59, 51, 43, 35, 27, 19, 11,  3, 60, 52, 44, 36,
      63, 55, 47, 39, 31, 23, 15,  7, 62, 54, 46, 38, 30, 22,
      14,  6, 61, 53, 45, 37, 29, 21, 13,  5, 28, 20, 12,  4};

   localparam int PC2_TAB [48] = '{
      14, 17, 11, 24,  1,  5,  3, 28, 15,  6, 21, 10,
      23, 19, 12,  4, 26,  8, 16,  7, 27, 20, 13,  2,
      41, 52, 31, 37, 47, 55, 30, 40, 51, 45, 33, 48,
      44, 49, 39, 56, 34, 53, 46, 42, 50, 36, 29, 32};

   function automatic logic [55:0] pc1(input logic [63:0] key);
      logic [55:0] r;
      r = '0;
      for (int i = 0; i < 56; i++) r[55-i] = key[64-PC1_TAB[i]];
      return r;
   endfunction

   function automatic logic [47:0] pc2(input logic [55:0] cd_in);
      logic [47:0] r;
      r = '0;
      for (int i = 0; i < 48; i++) r[47-i] = cd_in[56-PC2_TAB[i]];
      return r;
   endfunction

   state_t      state, state_nxt;
   logic [55:0] cd, cd_nxt;
   logic [3:0]  rnd_nxt;
   logic        shift2;
   logic [27:0] c_cur, d_cur;

   assign c_cur = cd[55:28];
   assign d_cur = cd[27:0];

   // Reversed encryption schedule: single-bit steps undo shifts 16, 9 and 2.
   assign shift2 = !((rnd == 4'd0) || (rnd == 4'd7) || (rnd == 4'd14));

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state <= IDLE;
         cd    <= '0;
         rnd   <= '0;
      end else begin
         state <= state_nxt;
         cd    <= cd_nxt;
         rnd   <= rnd_nxt;
      end
   end

   always_comb begin
      state_nxt = state;
      cd_nxt    = cd;
      rnd_nxt   = 4'd0;
      case (state)
         IDLE: begin
            if (req) begin
               state_nxt = RUN;
               cd_nxt    = pc1(k);
            end
         end
         RUN: begin
            if (rnd == 4'd15) begin
               state_nxt = DONE;
            end else begin
               rnd_nxt = rnd + 4'd1;
               if (shift2)
                  cd_nxt = {c_cur[1:0], c_cur[27:2], d_cur[1:0], d_cur[27:2]};
               else
                  cd_nxt = {c_cur[0], c_cur[27:1], d_cur[0], d_cur[27:1]};
            end
         end
         DONE: state_nxt = IDLE;
         default: state_nxt = IDLE;
      endcase
   end

   assign busy     = (state != IDLE);
   assign rk_valid = (state == RUN);
   assign done     = (state == DONE);
   assign rk       = pc2(cd);

`ifdef KEY_SCHED_DEC_PARITY_CHK_EN
   function automatic logic even_byte(input logic [63:0] key);
      logic e;
      e = 1'b0;
      for (int b = 0; b < 8; b++) e = e | ~(^key[8*b +: 8]);
      return e;
   endfunction

   always_ff @(posedge clk or posedge rst) begin
      if (rst)
         key_err <= 1'b0;
      else if ((state == IDLE) && req)
         key_err <= even_byte(k);
   end
`else
   // Parity bits are deliberately dropped by PC-1 when checking is disabled.
   logic parity_unused;
   assign parity_unused = ^{k[56], k[48], k[40], k[32], k[24], k[16], k[8], k[0]};
`endif

endmodule

// File: tb/tb_key_sched_dec.sv
// Bench for key_sched_dec: scoreboard of {rnd, rk} pairs against the FIPS 46 key table.
// Define KEY_SCHED_DEC_PARITY_CHK_EN to also exercise key_err.
module tb_key_sched_dec;

   localparam logic [63:0] KEY = 64'h1334_5779_9BBC_DFF1;

   // K1..K16 for KEY; decryption emits them in reverse order.
   localparam logic [47:0] KTAB [16] = '{
      48'h1B02EFFC7072, 48'h79AED9DBC9E5, 48'h55FC8A42CF99, 48'h72ADD6DB351D,
      48'h7CEC07EB53A8, 48'h63A53E507B2F, 48'hEC84B7F618BC, 48'hF78A3AC13BFB,
      48'hE0DBEBEDE781, 48'hB1F347BA464F, 48'h215FD3DED386, 48'h7571F59467E9,
      48'h97C5D1FABA41, 48'h5F43B7F2E73A, 48'hBF918D3D3F0A, 48'hCB3D8B0E17F5};

   // clock / reset
   logic        clk = 1'b0;
   logic        rst;
   logic        req;
   logic [63:0] k;
   logic        busy;
   logic [47:0] rk;
   logic        rk_valid;
   logic [3:0]  rnd;
   logic        done;
`ifdef KEY_SCHED_DEC_PARITY_CHK_EN
   logic        key_err;
`endif

   always #5 clk = ~clk;

   key_sched_dec dut (
      .clk      (clk),
      .rst      (rst),
      .req      (req),
      .k        (k),
      .busy     (busy),
      .rk       (rk),
      .rk_valid (rk_valid),
      .rnd      (rnd),
      .done     (done)
`ifdef KEY_SCHED_DEC_PARITY_CHK_EN
      ,
      .key_err  (key_err)
`endif
   );

   // scoreboard
   logic [51:0] exp_q[$];
   int n_vec   = 0;
   int n_err   = 0;
   int n_valid = 0;

   task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_vec++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s: got %h expected %h at %0t", tag, got, exp, $time);
      end
   endtask

   task automatic push_run();
      for (int r = 0; r < 16; r++) exp_q.push_back({4'(r), KTAB[15-r]});
   endtask

   // driver/monitor step: advance one edge, then pop and compare any valid round key
   task automatic step();
      logic [51:0] e;
      @(posedge clk);
      #1;
      if (rk_valid) begin
         n_valid++;
         if (exp_q.size() == 0) begin
            check("rk_unexpected", 64'(rk_valid), 64'd0);
         end else begin
            e = exp_q.pop_front();
            check("rnd_rk", {12'd0, rnd, rk}, {12'd0, e});
         end
      end
   endtask

   task automatic wait_done();
      int n;
      n = 0;
      while (!done && n < 40) begin
         step();
         n++;
      end
      check("done_seen", 64'(done), 64'd1);
   endtask

   initial begin
      #100000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1, "watchdog");
   end

   initial begin
      int v0;
      rst = 1'b1;
      req = 1'b0;
      k   = '0;
      #3;
      check("rst_busy",  64'(busy), 64'd0);
      check("rst_valid", 64'(rk_valid), 64'd0);
      check("rst_done",  64'(done), 64'd0);
      check("rst_rnd",   64'(rnd), 64'd0);
      check("rst_rk",    64'(rk), 64'd0);
`ifdef KEY_SCHED_DEC_PARITY_CHK_EN
      check("rst_key_err", 64'(key_err), 64'd0);
`endif
      step();
      step();
      rst = 1'b0;
      step();

      // single run: latency, all 16 keys, done at T+17
      k   = KEY;
      req = 1'b1;
      push_run();
      v0 = n_valid;
      step();
      req = 1'b0;
      check("busy_run", 64'(busy), 64'd1);
`ifdef KEY_SCHED_DEC_PARITY_CHK_EN
      check("key_err_good", 64'(key_err), 64'd0);
`endif
      for (int i = 0; i < 15; i++) begin
         step();
         check("done_early", 64'(done), 64'd0);
      end
      step();
      check("done_t17", 64'(done), 64'd1);
      check("valid_off_done", 64'(rk_valid), 64'd0);
      check("valid_cnt", 64'(n_valid - v0), 64'd16);
      step();
      check("done_pulse_end", 64'(done), 64'd0);
      check("idle_busy", 64'(busy), 64'd0);
      check("q_empty_1", 64'(exp_q.size()), 64'd0);

      // req held high: back-to-back runs with one idle cycle
      req = 1'b1;
      push_run();
      push_run();
      step();
      repeat (15) step();
      step();
      check("b2b_done1", 64'(done), 64'd1);
      step();
      check("b2b_gap_busy", 64'(busy), 64'd0);
      check("b2b_gap_valid", 64'(rk_valid), 64'd0);
      step();
      check("b2b_restart", 64'(rk_valid), 64'd1);
      req = 1'b0;
      repeat (15) step();
      step();
      check("b2b_done2", 64'(done), 64'd1);
      step();
      check("b2b_idle", 64'(busy), 64'd0);
      check("q_empty_2", 64'(exp_q.size()), 64'd0);

      // reset at rnd 7: asynchronous clear, no done, restart on first edge
      req = 1'b1;
      push_run();
      step();
      req = 1'b0;
      repeat (7) step();
      check("rnd7", 64'(rnd), 64'd7);
      #2;
      rst = 1'b1;
      #1;
      check("arst_busy",  64'(busy), 64'd0);
      check("arst_valid", 64'(rk_valid), 64'd0);
      check("arst_done",  64'(done), 64'd0);
      check("arst_rnd",   64'(rnd), 64'd0);
      check("arst_rk",    64'(rk), 64'd0);
      exp_q.delete();
      step();
      check("arst_no_done", 64'(done), 64'd0);
      rst = 1'b0;
      req = 1'b1;
      push_run();
      step();
      req = 1'b0;
      check("post_rst_run", 64'(rk_valid), 64'd1);
      wait_done();
      step();

      // k and req changed mid-run must be ignored
      req = 1'b1;
      push_run();
      step();
      req = 1'b0;
      repeat (5) step();
      check("rnd5", 64'(rnd), 64'd5);
      k   = 64'd0;
      req = 1'b1;
      step();
      req = 1'b0;
      wait_done();
      step();
      check("no_restart", 64'(busy), 64'd0);
      check("q_empty_3", 64'(exp_q.size()), 64'd0);

      // random idle gaps and random key noise during runs
      for (int it = 0; it < 3; it++) begin
         repeat ($urandom_range(1, 4)) step();
         k   = KEY;
         req = 1'b1;
         push_run();
         step();
         req = 1'b0;
         repeat ($urandom_range(1, 10)) step();
         k = {$urandom, $urandom};
         wait_done();
         step();
      end
      check("q_empty_4", 64'(exp_q.size()), 64'd0);

`ifdef KEY_SCHED_DEC_PARITY_CHK_EN
      // bad parity in the last byte: flag set, round keys unchanged
      k   = {KEY[63:1], 1'b0};
      req = 1'b1;
      push_run();
      step();
      req = 1'b0;
      k   = KEY;
      check("key_err_bad", 64'(key_err), 64'd1);
      wait_done();
      step();
      check("key_err_hold", 64'(key_err), 64'd1);
      check("q_empty_5", 64'(exp_q.size()), 64'd0);
      req = 1'b1;
      push_run();
      step();
      req = 1'b0;
      check("key_err_clear", 64'(key_err), 64'd0);
      wait_done();
      step();
`endif

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
